// File: rtl/simplecpu_pkg.sv
// Shared sizing for the simple CPU: ROM geometry and fetch buffer depth,
// used by both the ROM model and the core's fetch unit.
package simplecpu_pkg;

    localparam int ADDR_SIZE   = 11;
    localparam int WORD_SIZE   = 9;
    localparam int FETCH_DEPTH = 2;

    // True when n is a power of two and at least 2 (valid buffer depth).
    function automatic bit depth_ok(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch buffer: Depth entries of Width bits, with a
// single-cycle flush and an occupancy count used for fetch credit.
module fetch_fifo
    import simplecpu_pkg::*;
#(
    parameter int Width = WORD_SIZE + ADDR_SIZE,
    parameter int Depth = FETCH_DEPTH,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] rd_data,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointer and count update; flush discards everything, including a
    // push arriving in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < Depth; i++) mem_d[i] = mem_q[i];
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
    end

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // The fetch credit rule must keep the buffer from overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && (count_q == CntW'(Depth))));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential ROM reads under a credit limit so
// the prefetch buffer can never overflow, tags each returned word with its
// address, and flushes on redirect.
module fetch_unit
    import simplecpu_pkg::*;
#(
    parameter int AddrSize = ADDR_SIZE,
    parameter int WordSize = WORD_SIZE,
    parameter int Depth    = FETCH_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    output logic [AddrSize-1:0] rom_addr,
    output logic                rom_en,
    input  logic [WordSize-1:0] rom_do,
    output logic [WordSize-1:0] instr,
    output logic [AddrSize-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect,
    input  logic [AddrSize-1:0] redirect_addr
);

    localparam int CntW = $clog2(Depth) + 1;
    localparam int EntW = WordSize + AddrSize;

    if (!depth_ok(Depth)) begin : g_bad_depth
        $error("fetch_unit: Depth must be a power of two >= 2");
    end

    logic [AddrSize-1:0] fetch_pc_q, fetch_pc_d;
    logic [AddrSize-1:0] inflight_pc_q, inflight_pc_d;
    logic                inflight_q, inflight_d;

    logic                pop;
    logic                push;
    logic [CntW:0]       credit_used;
    logic [CntW-1:0]     fifo_count;
    logic                fifo_empty;
    logic [EntW-1:0]     fifo_rd;
    logic [EntW-1:0]     fifo_wr;

    // Issue, credit and redirect decisions for this cycle.
    always_comb begin
        // A redirect flushes, so a simultaneous consumer accept is dropped.
        pop  = instr_valid & instr_ready & ~redirect;
        // The response returning now belongs to the old stream on redirect.
        push = inflight_q & ~redirect;
        // Slots committed: buffered words plus the one still coming back,
        // minus the slot being freed this cycle.
        credit_used = (CntW+1)'(fifo_count) + (CntW+1)'(inflight_q)
                    - (CntW+1)'(pop);
        rom_en = ~rst & ~redirect & (credit_used < (CntW+1)'(Depth));

        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = rom_en;
        if (redirect) begin
            fetch_pc_d = redirect_addr;
        end else if (rom_en) begin
            fetch_pc_d    = fetch_pc_q + AddrSize'(1);
            inflight_pc_d = fetch_pc_q;
        end
        fetch_pc_d = fetch_pc_d;
    end

    // Fetch state; reset outranks redirect and drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= '0;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    // rom_do is only looked at when a live response is due this cycle.
    assign fifo_wr = push ? {rom_do, inflight_pc_q} : '0;

    fetch_fifo #(
        .Width (EntW),
        .Depth (Depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (fifo_wr),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rom_addr    = fetch_pc_q;
    assign instr_valid = ~fifo_empty;
    assign instr       = fifo_rd[EntW-1:AddrSize];
    assign instr_pc    = fifo_rd[AddrSize-1:0];

endmodule
